// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: job sequencer for one systolic_array tile.
// Latches the per-job precision/sign config, pulses the weight-load strobe,
// streams num_vecs vectors from the input buffer with per-row skew, and
// tags each psum vector as it leaves the bottom row.
// Optional busy-cycle counter: define SYSTOLIC_CTRL_PERF_CNT_EN.
module systolic_array_ctrl #(
    parameter int unsigned ARRAY_SIZE     = 8,
    parameter int unsigned LOG_ARRAY_SIZE = 3,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned FU_LATENCY     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       num_vecs,
    input  logic [3:0]              cfg_in_width,
    input  logic [3:0]              cfg_weight_width,
    input  logic                    cfg_s_in,
    input  logic                    cfg_s_weight,
    output logic                    busy,
    output logic                    done,
    output logic                    w_load,
    output logic                    in_rd_en,
    output logic [ADDR_W-1:0]       in_rd_addr,
    input  logic [ARRAY_SIZE*8-1:0] in_vec,
    output logic [ARRAY_SIZE*8-1:0] arr_inputs,
    output logic [3:0]              arr_in_width,
    output logic [3:0]              arr_weight_width,
    output logic                    arr_s_in,
    output logic                    arr_s_weight,
    output logic                    psum_valid,
    output logic [ADDR_W-1:0]       psum_addr,
    output logic [31:0]             cycle_count
);

    // Read-to-psum latency: buffer read (1) + skew entry (1) + one
    // FU_LATENCY slice per array row.
    localparam int unsigned PIPE_DEPTH = 2 + (FU_LATENCY << LOG_ARRAY_SIZE);
    localparam int unsigned DRAIN_W    = $clog2(PIPE_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   num_vecs_q;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [PIPE_DEPTH-1:0] pv_q;
    logic [ADDR_W-1:0]   pa_q [PIPE_DEPTH];

    // Job sequencer with registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            w_load           <= 1'b0;
            in_rd_en         <= 1'b0;
            in_rd_addr       <= '0;
            num_vecs_q       <= '0;
            drain_cnt        <= '0;
            arr_in_width     <= '0;
            arr_weight_width <= '0;
            arr_s_in         <= 1'b0;
            arr_s_weight     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_vecs_q       <= num_vecs;
                        arr_in_width     <= cfg_in_width;
                        arr_weight_width <= cfg_weight_width;
                        arr_s_in         <= cfg_s_in;
                        arr_s_weight     <= cfg_s_weight;
                        busy             <= 1'b1;
                        w_load           <= 1'b1;
                        state            <= WLOAD;
                    end
                end
                WLOAD: begin
                    w_load <= 1'b0;
                    if (num_vecs_q == '0) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        in_rd_en   <= 1'b1;
                        in_rd_addr <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_rd_addr == num_vecs_q - ADDR_W'(1)) begin
                        in_rd_en   <= 1'b0;
                        in_rd_addr <= '0;
                        drain_cnt  <= DRAIN_W'(PIPE_DEPTH - 1);
                        state      <= DRAIN;
                    end else begin
                        in_rd_addr <= in_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid/index pipeline tracking each read through to the bottom row;
    // stage 0 doubles as the "buffer data valid" flag for the skew rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) pa_q[k] <= '0;
        end else begin
            pv_q    <= {pv_q[PIPE_DEPTH-2:0], in_rd_en};
            pa_q[0] <= in_rd_addr;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) pa_q[k] <= pa_q[k-1];
        end
    end

    assign psum_valid = pv_q[PIPE_DEPTH-1];
    assign psum_addr  = pa_q[PIPE_DEPTH-1];

    // Per-row skew: row r delays its byte by 1 + r*FU_LATENCY registers.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        localparam int unsigned DEPTH = 1 + r * FU_LATENCY;
        logic [7:0] sk_q [DEPTH];

        // Shift buffer bytes in when the read data is valid, zeros otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < DEPTH; k++) sk_q[k] <= '0;
            end else begin
                sk_q[0] <= pv_q[0] ? in_vec[r*8 +: 8] : 8'h00;
                for (int unsigned k = 1; k < DEPTH; k++) sk_q[k] <= sk_q[k-1];
            end
        end

        assign arr_inputs[r*8 +: 8] = sk_q[DEPTH-1];
    end

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;

    // Busy-cycle counter: cleared on accepted start, holds once idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt_q <= '0;
        end else if (busy) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: a job-level model predicts
// every output from the cycle offset into the current job.
module tb_systolic_array_ctrl;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int AW   = 10;
    localparam int L    = 1;
    localparam int D    = 2 + N * L;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, start;
    logic [AW-1:0]   num_vecs;
    logic [3:0]      cfg_in_width, cfg_weight_width;
    logic            cfg_s_in, cfg_s_weight;
    logic            busy, done, w_load, in_rd_en;
    logic [AW-1:0]   in_rd_addr;
    logic [N*8-1:0]  in_vec, arr_inputs;
    logic [3:0]      arr_in_width, arr_weight_width;
    logic            arr_s_in, arr_s_weight, psum_valid;
    logic [AW-1:0]   psum_addr;
    logic [31:0]     cycle_count;

    systolic_array_ctrl #(
        .ARRAY_SIZE(N), .LOG_ARRAY_SIZE(LOGN), .ADDR_W(AW), .FU_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
        .busy(busy), .done(done), .w_load(w_load),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_vec(in_vec),
        .arr_inputs(arr_inputs), .arr_in_width(arr_in_width),
        .arr_weight_width(arr_weight_width), .arr_s_in(arr_s_in),
        .arr_s_weight(arr_s_weight), .psum_valid(psum_valid),
        .psum_addr(psum_addr), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Buffer contents: vector a, byte i.
    function automatic logic [7:0] mem_byte(input int a, input int i);
        return 8'((a * 32 + 16 + i) & 255);
    endfunction

    function automatic logic [N*8-1:0] mem_vec(input int a);
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = mem_byte(a, i);
        return v;
    endfunction

    // Input buffer: data for a read in cycle t appears in cycle t+1;
    // non-read cycles present junk that must never reach the array.
    logic          pend_en;
    logic [AW-1:0] pend_addr;
    initial begin
        logic [N*8-1:0] junk;
        junk = {N{8'hEE}};
        in_vec = junk;
        forever begin
            @(negedge clk);
            pend_en   = in_rd_en;
            pend_addr = in_rd_addr;
            @(posedge clk);
            #1;
            in_vec = (pend_en === 1'b1) ? mem_vec(int'(pend_addr)) : junk;
        end
    end

    // Job model: rel = cycles since the accepting edge (WLOAD is rel 1).
    int       cyc = 0;
    bit       chk_en = 1'b0;
    bit       job_on = 1'b0;
    int       rel = 0, job_n = 0, job_total = 0, m_cc_hold = 0;
    logic [3:0] m_iw = '0, m_ww = '0;
    logic     m_si = 1'b0, m_sw = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst === 1'b1) begin
            job_on = 1'b0; rel = 0; m_cc_hold = 0;
            m_iw = '0; m_ww = '0; m_si = 1'b0; m_sw = 1'b0;
            chk_en = 1'b1;
        end else if (job_on) begin
            if (rel == job_total) begin
                job_on = 1'b0;
                m_cc_hold = job_total;
            end else begin
                rel++;
            end
        end else if (start === 1'b1) begin
            job_on = 1'b1; rel = 1;
            job_n = int'(num_vecs);
            job_total = (job_n == 0) ? 3 : (2 + job_n + D);
            m_iw = cfg_in_width; m_ww = cfg_weight_width;
            m_si = cfg_s_in; m_sw = cfg_s_weight;
        end
    end

    // Event monitor state (cleared per test).
    int n_wl, n_rd, n_ps, n_done, wl_cyc, rd0_cyc, ps0_cyc, done_cyc, rd_max;
    int row_cyc [N];

    task automatic clr_mon();
        n_wl = 0; n_rd = 0; n_ps = 0; n_done = 0;
        wl_cyc = -1; rd0_cyc = -1; ps0_cyc = -1; done_cyc = -1; rd_max = -1;
        for (int i = 0; i < N; i++) row_cyc[i] = -1;
    endtask

    // Per-cycle compare against the model, plus event bookkeeping.
    initial begin
        clr_mon();
        forever begin
            logic [N*8-1:0] e_arr;
            bit e_rd, e_pv;
            int k, e_cc;
            @(negedge clk);
            if (chk_en) begin
                e_arr = '0;
                for (int i = 0; i < N; i++) begin
                    k = rel - 4 - i * L;
                    if (job_on && k >= 0 && k < job_n) e_arr[i*8 +: 8] = mem_byte(k, i);
                end
                e_rd = job_on && job_n > 0 && rel >= 2 && rel <= 1 + job_n;
                e_pv = job_on && rel >= 2 + D && rel <= 1 + job_n + D;
                e_cc = PERF ? (job_on ? rel - 1 : m_cc_hold) : 0;
                chk("busy", busy, job_on);
                chk("done", done, job_on && rel == job_total);
                chk("w_load", w_load, job_on && rel == 1);
                chk("in_rd_en", in_rd_en, e_rd);
                if (e_rd) chk("in_rd_addr", in_rd_addr, rel - 2);
                chk("psum_valid", psum_valid, e_pv);
                if (e_pv) chk("psum_addr", psum_addr, rel - 2 - D);
                chk("arr_inputs", arr_inputs, e_arr);
                chk("arr_cfg", {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight},
                    {m_iw, m_ww, m_si, m_sw});
                chk("cycle_count", cycle_count, e_cc);

                if (w_load === 1'b1) begin n_wl++; wl_cyc = cyc; end
                if (done === 1'b1) begin n_done++; done_cyc = cyc; end
                if (in_rd_en === 1'b1) begin
                    n_rd++;
                    if (int'(in_rd_addr) > rd_max) rd_max = int'(in_rd_addr);
                    if (in_rd_addr == 0 && rd0_cyc < 0) rd0_cyc = cyc;
                end
                if (psum_valid === 1'b1) begin
                    n_ps++;
                    if (psum_addr == 0 && ps0_cyc < 0) ps0_cyc = cyc;
                end
                for (int i = 0; i < N; i++)
                    if (row_cyc[i] < 0 && arr_inputs[i*8 +: 8] == mem_byte(0, i)) row_cyc[i] = cyc;
            end
        end
    end

    function automatic bit ev(input int which);
        case (which)
            0:       return done === 1'b1;
            1:       return w_load === 1'b1;
            default: return in_rd_en === 1'b1 && in_rd_addr == 2;
        endcase
    endfunction

    task automatic wait_ev(input int which, input int budget, input string tag);
        int k = 0;
        while (!ev(which) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, ev(which), 1'b1);
    endtask

    task automatic go(input int n, input logic [3:0] iw, input logic [3:0] ww,
                      input logic si, input logic sw);
        num_vecs = AW'(n); cfg_in_width = iw; cfg_weight_width = ww;
        cfg_s_in = si; cfg_s_weight = sw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int d1;
        rst = 1'b1; start = 1'b0; num_vecs = '0;
        cfg_in_width = '0; cfg_weight_width = '0; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, w_load, in_rd_en, psum_valid}, '0);
        chk("reset_arr", arr_inputs, '0);
        chk("reset_cc", cycle_count, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-vector job, 8/8 unsigned.
        clr_mon();
        go(4, 4'd8, 4'd8, 1'b0, 1'b0);
        wait_ev(0, 100, "t1_done");
        repeat (2) @(negedge clk);
        chk("t1_wload_count", n_wl, 1);
        chk("t1_read_count", n_rd, 4);
        chk("t1_read_max", rd_max, 3);
        chk("t1_psum_count", n_ps, 4);
        chk("t1_done_count", n_done, 1);
        chk("t1_psum_latency", ps0_cyc - rd0_cyc, 10);
        for (int i = 0; i < N; i++) chk("t1_row_skew", row_cyc[i] - rd0_cyc, 2 + i);
        chk("t1_done_after_wload", done_cyc - wl_cyc, 15);
        chk("t1_cycle_count", cycle_count, PERF ? 16 : 0);
        chk("t1_cfg", {arr_in_width, arr_weight_width}, {4'd8, 4'd8});

        // Empty job.
        clr_mon();
        go(0, 4'd2, 4'd4, 1'b1, 1'b1);
        wait_ev(0, 50, "t2_done");
        repeat (2) @(negedge clk);
        chk("t2_wload_count", n_wl, 1);
        chk("t2_read_count", n_rd, 0);
        chk("t2_psum_count", n_ps, 0);
        chk("t2_done_after_wload", done_cyc - wl_cyc, 2);
        chk("t2_cycle_count", cycle_count, PERF ? 3 : 0);

        // Start held high, config changed mid-job, back-to-back second job.
        clr_mon();
        num_vecs = AW'(3); cfg_in_width = 4'd4; cfg_weight_width = 4'd2;
        cfg_s_in = 1'b1; cfg_s_weight = 1'b0; start = 1'b1;
        @(negedge clk);
        num_vecs = AW'(2); cfg_in_width = 4'd6; cfg_weight_width = 4'd3;
        cfg_s_in = 1'b0; cfg_s_weight = 1'b1;
        wait_ev(0, 100, "t3_done1");
        d1 = cyc;
        chk("t3_cfg_held", {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight},
            {4'd4, 4'd2, 1'b1, 1'b0});
        @(negedge clk);
        wait_ev(1, 10, "t3_wload2");
        chk("t3_restart_gap", cyc - d1, 2);
        start = 1'b0;
        chk("t3_cfg_new", {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight},
            {4'd6, 4'd3, 1'b0, 1'b1});
        wait_ev(0, 100, "t3_done2");
        repeat (2) @(negedge clk);
        chk("t3_wload_count", n_wl, 2);
        chk("t3_read_count", n_rd, 5);
        chk("t3_psum_count", n_ps, 5);
        chk("t3_done_count", n_done, 2);

        // Reset during streaming at address 2, then a fresh job.
        clr_mon();
        go(5, 4'd8, 4'd8, 1'b1, 1'b1);
        wait_ev(2, 20, "t4_addr2");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_ctrl_cleared", {busy, done, w_load, in_rd_en, psum_valid}, '0);
        chk("t4_arr_cleared", arr_inputs, '0);
        chk("t4_cfg_cleared", {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight}, '0);
        chk("t4_cc_cleared", cycle_count, '0);
        repeat (20) @(negedge clk);
        chk("t4_no_done", n_done, 0);
        chk("t4_no_psum", n_ps, 0);
        clr_mon();
        go(2, 4'd8, 4'd4, 1'b0, 1'b1);
        wait_ev(0, 100, "t4_done");
        repeat (2) @(negedge clk);
        chk("t4_read_count", n_rd, 2);
        chk("t4_psum_count", n_ps, 2);
        chk("t4_psum_latency", ps0_cyc - rd0_cyc, 10);
        chk("t4_done_after_wload", done_cyc - wl_cyc, 13);
        chk("t4_cycle_count", cycle_count, PERF ? 14 : 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
